mbist_march_ctrl: RTL and testbench

Memory BIST initiator that drives the memory-side port (write_read, address, wdata, rdata) of the 32-bit, 1-cycle-write-setup, 2-cycle-read-latency test memory. It runs a March C- sequence over a configurable address range, compares every read against the expected background, and records pass/fail plus first-failure diagnostics. It sits between the BIST top-level sequencer (start/done) and the memory under test.

---
 rtl/mbist_march_ctrl_if.sv | 39 +++
 rtl/mbist_march_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mbist_march_ctrl_if.sv
// Bundle of sequencer handshake, result and memory-side signals for the
// March C- BIST controller.
//
// Handshake: start is a one-cycle request that is accepted only when the
// controller is idle or done; busy is high from the cycle after acceptance
// until done rises; done (with pass/fail results) then holds until the next
// accepted start or reset. The memory side has no flow control: write_read=1
// is a write of the wdata presented in the previous cycle, write_read=0 is a
// read whose rdata returns two cycles later.
interface mbist_march_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic                  fail;
  logic [ADDR_WIDTH-1:0] fail_addr;
  logic [DATA_WIDTH-1:0] fail_data;
  logic [2:0]            fail_elem;
  logic [15:0]           err_cnt;
  logic                  write_read;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    input  start, rdata,
    output busy, done, pass, fail, fail_addr, fail_data, fail_elem, err_cnt,
    output write_read, address, wdata
  );

  modport slave (
    output start, rdata,
    input  busy, done, pass, fail, fail_addr, fail_data, fail_elem, err_cnt,
    input  write_read, address, wdata
  );
endinterface

// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller: walks six march elements over
// [0, LAST_ADDR], checks every read two cycles later against the expected
// background and keeps first-failure diagnostics plus a saturating error count.
module mbist_march_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int LAST_ADDR  = 65535
) (
  input  logic               clk,
  input  logic               rst,
  mbist_march_ctrl_if.master bus,
  output logic [2:0]         dbg_state
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LAST_ADDR);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [2:0]            elem_q, elem_d;
  logic                  phase_q, phase_d;   // 0 = read/single op, 1 = write of pair
  logic                  drain_q, drain_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic                  fail_q, fail_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;
  logic [2:0]            fail_elem_q, fail_elem_d;
  logic [15:0]           err_cnt_q, err_cnt_d;
  // read check pipeline: expected value is a background bit (0 or all ones)
  logic                  p1_vld_q, p1_vld_d, p2_vld_q, p2_vld_d;
  logic [ADDR_WIDTH-1:0] p1_addr_q, p1_addr_d, p2_addr_q, p2_addr_d;
  logic                  p1_exp_q, p1_exp_d, p2_exp_q, p2_exp_d;
  logic [2:0]            p1_elem_q, p1_elem_d, p2_elem_q, p2_elem_d;
  logic                  miscompare;

  // E1 and E3 write ones; every other element writes zeros
  function automatic logic elem_wval(input logic [2:0] e);
    return (e == 3'd1) || (e == 3'd3);
  endfunction
  // E2 and E4 expect ones on their reads
  function automatic logic elem_rval(input logic [2:0] e);
    return (e == 3'd2) || (e == 3'd4);
  endfunction
  function automatic logic elem_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction
  function automatic logic elem_two(input logic [2:0] e);
    return (e >= 3'd1) && (e <= 3'd4);
  endfunction

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.fail       = fail_q;
  assign bus.fail_addr  = fail_addr_q;
  assign bus.fail_data  = fail_data_q;
  assign bus.fail_elem  = fail_elem_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.write_read = wr_q;
  assign bus.address    = addr_q;
  assign bus.wdata      = wdata_q;
  assign dbg_state      = state_q;

  assign miscompare = p2_vld_q && (bus.rdata != {DATA_WIDTH{p2_exp_q}});

  // Next-state, next-op and result logic; outputs are registered from these
  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    phase_d     = phase_q;
    drain_d     = drain_q;
    wr_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    fail_elem_d = fail_elem_q;
    err_cnt_d   = err_cnt_q;

    // a non-write RUN cycle is a read whose data returns two cycles later
    p1_vld_d  = (state_q == S_RUN) && !wr_q;
    p1_addr_d = addr_q;
    p1_exp_d  = elem_rval(elem_q);
    p1_elem_d = elem_q;
    p2_vld_d  = p1_vld_q;
    p2_addr_d = p1_addr_q;
    p2_exp_d  = p1_exp_q;
    p2_elem_d = p1_elem_q;

    if (miscompare) begin
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      if (!fail_q) begin
        fail_d      = 1'b1;
        fail_addr_d = p2_addr_q;
        fail_data_d = bus.rdata;
        fail_elem_d = p2_elem_q;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d     = S_SETUP;
          elem_d      = 3'd0;
          phase_d     = 1'b0;
          addr_d      = '0;
          wdata_d     = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_data_d = '0;
          fail_elem_d = 3'd0;
          err_cnt_d   = '0;
        end
      end
      S_SETUP: begin
        state_d = S_RUN;
        phase_d = 1'b0;
        wr_d    = (elem_q == 3'd0);
      end
      S_RUN: begin
        if (elem_two(elem_q) && !phase_q) begin
          phase_d = 1'b1;
          wr_d    = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (addr_q == (elem_down(elem_q) ? '0 : LAST)) begin
            if (elem_q == 3'd5) begin
              state_d = S_DRAIN;
              drain_d = 1'b0;
            end else begin
              state_d = S_SETUP;
              elem_d  = elem_q + 3'd1;
              addr_d  = elem_down(elem_q + 3'd1) ? LAST : '0;
              wdata_d = {DATA_WIDTH{elem_wval(elem_q + 3'd1)}};
            end
          end else begin
            addr_d = elem_down(elem_q) ? addr_q - ADDR_WIDTH'(1) : addr_q + ADDR_WIDTH'(1);
            wr_d   = (elem_q == 3'd0);
          end
        end
      end
      S_DRAIN: begin
        if (!drain_q) begin
          drain_d = 1'b1;
        end else begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = ~fail_d;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Single state register for the FSM, its registered outputs and the check pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      elem_q      <= 3'd0;
      phase_q     <= 1'b0;
      drain_q     <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      fail_elem_q <= 3'd0;
      err_cnt_q   <= '0;
      p1_vld_q    <= 1'b0;
      p1_addr_q   <= '0;
      p1_exp_q    <= 1'b0;
      p1_elem_q   <= 3'd0;
      p2_vld_q    <= 1'b0;
      p2_addr_q   <= '0;
      p2_exp_q    <= 1'b0;
      p2_elem_q   <= 3'd0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      phase_q     <= phase_d;
      drain_q     <= drain_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      fail_elem_q <= fail_elem_d;
      err_cnt_q   <= err_cnt_d;
      p1_vld_q    <= p1_vld_d;
      p1_addr_q   <= p1_addr_d;
      p1_exp_q    <= p1_exp_d;
      p1_elem_q   <= p1_elem_d;
      p2_vld_q    <= p2_vld_d;
      p2_addr_q   <= p2_addr_d;
      p2_exp_q    <= p2_exp_d;
      p2_elem_q   <= p2_elem_d;
    end
  end
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl with an 8-word memory model (1-cycle write data
// setup, 2-cycle read latency, optional stuck read value at one address).
module tb_mbist_march_ctrl;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int LAST = 7;

  typedef struct {
    bit          fault_en;
    logic [15:0] fault_addr;
    logic [31:0] fault_val;
    int          exp_lat;
    bit          exp_pass;
    logic [15:0] exp_err;
    logic [15:0] exp_faddr;
    logic [2:0]  exp_felem;
    logic [31:0] exp_fdata;
  } vec_t;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
  } tr_t;

  // clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] dbg_state;
  always #5 clk = ~clk;

  mbist_march_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LAST_ADDR(LAST)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // scoreboard state
  int total = 0;
  int bad   = 0;
  tr_t trace_q[$];
  tr_t exp_q[$];
  logic [DW-1:0] exp_mem_q[$];

  // memory model
  logic [DW-1:0] mem [0:LAST];
  logic [DW-1:0] rd_pipe0 = '0;
  logic [DW-1:0] rd_pipe1 = '0;
  logic [DW-1:0] prev_wdata = '0;
  bit            fault_en = 1'b0;
  logic [15:0]   fault_addr = '0;
  logic [31:0]   fault_val = '0;

  always @(negedge clk) begin
    tr_t t;
    bus.rdata = rd_pipe1;
    rd_pipe1  = rd_pipe0;
    rd_pipe0  = (fault_en && bus.address == fault_addr) ? fault_val : mem[bus.address[2:0]];
    t.wr   = bus.write_read;
    t.addr = bus.address;
    t.data = bus.write_read ? prev_wdata : '0;
    if (bus.write_read) mem[bus.address[2:0]] = prev_wdata;
    prev_wdata = bus.wdata;
    if (bus.busy) trace_q.push_back(t);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // expected op trace of one run: SETUP entry, then the element's ops
  task automatic build_exp();
    tr_t t;
    exp_q.delete();
    for (int e = 0; e < 6; e++) begin
      bit down = (e == 3) || (e == 4);
      logic [31:0] wv = ((e == 1) || (e == 3)) ? 32'hFFFFFFFF : 32'h0;
      t.wr = 1'b0; t.addr = down ? 16'(LAST) : 16'd0; t.data = '0;
      exp_q.push_back(t);
      for (int i = 0; i <= LAST; i++) begin
        logic [15:0] a = down ? 16'(LAST - i) : 16'(i);
        if (e == 0) begin
          t.wr = 1'b1; t.addr = a; t.data = 32'h0; exp_q.push_back(t);
        end else if (e == 5) begin
          t.wr = 1'b0; t.addr = a; t.data = 32'h0; exp_q.push_back(t);
        end else begin
          t.wr = 1'b0; t.addr = a; t.data = 32'h0; exp_q.push_back(t);
          t.wr = 1'b1; t.addr = a; t.data = wv;    exp_q.push_back(t);
        end
      end
    end
  endtask

  // driver: pulse start, optionally pulse it again at cycle extra, wait for done
  task automatic do_run(input int extra, output int lat);
    int cyc;
    trace_q.delete();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (!bus.done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      bus.start = (cyc == extra);
    end
    bus.start = 1'b0;
    if (!bus.done) chk("done_timeout", 64'(cyc), 64'd89);
    lat = cyc - 1;
  endtask

  task automatic check_trace();
    int writes;
    chk("trace_len", 64'(trace_q.size()), 64'(10 * (LAST + 1) + 8));
    writes = 0;
    foreach (trace_q[i]) if (trace_q[i].wr) writes++;
    chk("write_count", 64'(writes), 64'(5 * (LAST + 1)));
    chk("nonwrite_busy_cycles", 64'(trace_q.size() - writes), 64'(5 * (LAST + 1) + 8));
    for (int i = 0; i < exp_q.size() && i < trace_q.size(); i++) begin
      chk($sformatf("op_wr[%0d]", i), 64'(trace_q[i].wr), 64'(exp_q[i].wr));
      chk($sformatf("op_addr[%0d]", i), 64'(trace_q[i].addr), 64'(exp_q[i].addr));
      if (exp_q[i].wr) chk($sformatf("op_wdata[%0d]", i), 64'(trace_q[i].data), 64'(exp_q[i].data));
    end
    for (int a = 0; a <= LAST; a++) chk($sformatf("final_mem[%0d]", a), 64'(mem[a]), 64'(exp_mem_q[a]));
  endtask

  task automatic load_mem(input vec_t v);
    fault_en   = v.fault_en;
    fault_addr = v.fault_addr;
    fault_val  = v.fault_val;
    for (int a = 0; a <= LAST; a++) mem[a] = $urandom_range(32'hFFFFFFFF, 0);
  endtask

  vec_t vecs[5];

  initial begin
    int lat;
    vecs[0] = '{1'b0, 16'd0, 32'h0,        88, 1'b1, 16'd0, 16'd0, 3'd0, 32'h0};
    vecs[1] = '{1'b1, 16'd5, 32'h000000AB, 88, 1'b0, 16'd5, 16'd5, 3'd1, 32'h000000AB};
    vecs[2] = '{1'b1, 16'd0, 32'hFFFFFFFF, 88, 1'b0, 16'd3, 16'd0, 3'd1, 32'hFFFFFFFF};
    vecs[3] = '{1'b1, 16'd7, 32'h0,        88, 1'b0, 16'd2, 16'd7, 3'd2, 32'h0};
    vecs[4] = '{1'b1, 16'd7, 32'h00000001, 88, 1'b0, 16'd5, 16'd7, 3'd1, 32'h00000001};
    build_exp();
    exp_mem_q.delete();
    for (int a = 0; a <= LAST; a++) exp_mem_q.push_back('0);

    bus.start = 1'b0;
    bus.rdata = '0;
    for (int a = 0; a <= LAST; a++) mem[a] = '0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_write_read", 64'(bus.write_read), 64'd0);
    chk("rst_address", 64'(bus.address), 64'd0);
    chk("rst_wdata", 64'(bus.wdata), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // table-driven runs
    for (int v = 0; v < 5; v++) begin
      load_mem(vecs[v]);
      do_run(0, lat);
      chk($sformatf("v%0d_latency", v), 64'(lat), 64'(vecs[v].exp_lat));
      chk($sformatf("v%0d_busy", v), 64'(bus.busy), 64'd0);
      chk($sformatf("v%0d_pass", v), 64'(bus.pass), 64'(vecs[v].exp_pass));
      chk($sformatf("v%0d_fail", v), 64'(bus.fail), 64'(!vecs[v].exp_pass));
      chk($sformatf("v%0d_err_cnt", v), 64'(bus.err_cnt), 64'(vecs[v].exp_err));
      chk($sformatf("v%0d_fail_addr", v), 64'(bus.fail_addr), 64'(vecs[v].exp_faddr));
      chk($sformatf("v%0d_fail_elem", v), 64'(bus.fail_elem), 64'(vecs[v].exp_felem));
      chk($sformatf("v%0d_fail_data", v), 64'(bus.fail_data), 64'(vecs[v].exp_fdata));
      check_trace();
      repeat (2) @(negedge clk);
    end

    // start in DONE after a failing run: results clear, clean rerun
    chk("done_hold", 64'(bus.done), 64'd1);
    load_mem(vecs[0]);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("restart_done_clr", 64'(bus.done), 64'd0);
    chk("restart_pass_clr", 64'(bus.pass), 64'd0);
    chk("restart_fail_clr", 64'(bus.fail), 64'd0);
    chk("restart_err_clr", 64'(bus.err_cnt), 64'd0);
    chk("restart_busy", 64'(bus.busy), 64'd1);
    begin
      int cyc = 1;
      while (!bus.done && cyc < 2000) begin @(negedge clk); cyc++; end
      chk("restart_latency", 64'(cyc - 1), 64'd88);
      chk("restart_pass", 64'(bus.pass), 64'd1);
    end

    // start pulsed while busy is ignored
    load_mem(vecs[0]);
    do_run(20, lat);
    chk("busy_start_latency", 64'(lat), 64'd88);
    chk("busy_start_pass", 64'(bus.pass), 64'd1);

    // reset in the middle of E2
    load_mem(vecs[1]);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (32) @(negedge clk);
    chk("mid_e2_busy_before", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_err_cnt", 64'(bus.err_cnt), 64'd0);
    chk("mid_rst_fail", 64'(bus.fail), 64'd0);
    chk("mid_rst_fail_addr", 64'(bus.fail_addr), 64'd0);
    chk("mid_rst_address", 64'(bus.address), 64'd0);
    chk("mid_rst_wdata", 64'(bus.wdata), 64'd0);
    chk("mid_rst_state", 64'(dbg_state), 64'd0);
    bus.start = 1'b1;
    @(negedge clk);
    chk("rst_wins_state", 64'(dbg_state), 64'd0);
    chk("rst_hold_write_read", 64'(bus.write_read), 64'd0);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load_mem(vecs[0]);
    do_run(0, lat);
    chk("post_rst_latency", 64'(lat), 64'd88);
    chk("post_rst_pass", 64'(bus.pass), 64'd1);
    chk("post_rst_err_cnt", 64'(bus.err_cnt), 64'd0);
    check_trace();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
